gradient_engine: RTL and testbench

- Parametrised Sobel gradient stage. Each start, one new pixel row of TILE_W pixels is shifted into a 3-row window, and TILE_W-2 magnitude/angle pairs are computed through a 3-stage pipeline, one column per cycle.
- Sits between the anchor/row fetch logic and non-maximum suppression. Generalises the fixed 16-pixel, 2-bit-angle gradient controller in width, scaling and error reporting.

---
 rtl/gradient_engine.sv | 151 +++++++++++++++
 tb/tb_gradient_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gradient_engine.sv
// Sobel gradient stage: shifts one row into a 3-row window and emits TILE_W-2
// saturated magnitude / 2-bit angle pairs through a 3-stage column pipeline.
// Optional GRADIENT_THRESH_EN adds a mag_thresh port that zeroes weak results.
module gradient_engine #(
  parameter int TILE_W    = 16,
  parameter int PIX_BITS  = 8,
  parameter int MAG_BITS  = 8,
  parameter int MAG_SHIFT = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              row_first,
  input  logic [TILE_W*PIX_BITS-1:0]        row_in,
`ifdef GRADIENT_THRESH_EN
  input  logic [MAG_BITS-1:0]               mag_thresh,
`endif
  output logic [(TILE_W-2)*MAG_BITS-1:0]    grad_mag,
  output logic [(TILE_W-2)*2-1:0]           grad_angle,
  output logic                              busy,
  output logic                              done,
  output logic                              overrun
);
  localparam int N  = TILE_W - 2;
  localparam int IW = $clog2(TILE_W) + 1;
  localparam int SW = PIX_BITS + 3;
  localparam int AW = PIX_BITS + 2;
  localparam logic [IW-1:0] LAST    = IW'(N + 1);
  localparam logic [31:0]   MAG_MAX = 32'((1 << MAG_BITS) - 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  logic [TILE_W*PIX_BITS-1:0] r0, r1, r2;
  logic [IW-1:0]              idx, base, wcol;
  logic signed [SW-1:0]       sm_n [3], df_n [3], sm_q [3], df_q [3];
  logic signed [SW-1:0]       gx_q, gy_q;
  logic [AW-1:0]              ax, ay;
  logic [31:0]                sum_w, sh_w;
  logic [MAG_BITS-1:0]        mag_w;
  logic [1:0]                 ang_w;
  logic                       accept;
`ifdef GRADIENT_THRESH_EN
  logic [MAG_BITS-1:0]        thresh_q;
`endif

  function automatic logic signed [SW-1:0] px(input logic [TILE_W*PIX_BITS-1:0] r, input int c);
    return SW'(r[c*PIX_BITS +: PIX_BITS]);
  endfunction

  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (idx == LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0 <= '0; r1 <= '0; r2 <= '0; idx <= '0;
      done <= 1'b0; overrun <= 1'b0;
`ifdef GRADIENT_THRESH_EN
      thresh_q <= '0;
`endif
    end else begin
      done    <= (state == RUN) && (idx == LAST);
      overrun <= (state == RUN) && start;
      if (accept) begin
        if (row_first) begin
          r0 <= row_in; r1 <= row_in; r2 <= row_in;
        end else begin
          r2 <= r1; r1 <= r0; r0 <= row_in;
        end
        idx <= '0;
`ifdef GRADIENT_THRESH_EN
        thresh_q <= mag_thresh;
`endif
      end else if (state == RUN && idx != LAST) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Stage 1 operands: vertical smoothing and row difference for columns c..c+2.
  always_comb begin
    base = (idx < IW'(N)) ? idx : '0;
    for (int k = 0; k < 3; k++) begin
      sm_n[k] = px(r2, int'(base) + k) + (px(r1, int'(base) + k) <<< 1) + px(r0, int'(base) + k);
      df_n[k] = px(r0, int'(base) + k) - px(r2, int'(base) + k);
    end
  end

  // Stage 3 operands: L1 magnitude with saturation, angle by 2:5 slope bins.
  always_comb begin
    ax    = AW'(gx_q[SW-1] ? -gx_q : gx_q);
    ay    = AW'(gy_q[SW-1] ? -gy_q : gy_q);
    sum_w = 32'(ax) + 32'(ay);
    sh_w  = sum_w >> MAG_SHIFT;
    mag_w = (sh_w > MAG_MAX) ? '1 : sh_w[MAG_BITS-1:0];
    if (32'd5 * 32'(ay) <= 32'd2 * 32'(ax))      ang_w = 2'd0;
    else if (32'd5 * 32'(ax) <= 32'd2 * 32'(ay)) ang_w = 2'd2;
    else if (gx_q[SW-1] == gy_q[SW-1])           ang_w = 2'd1;
    else                                         ang_w = 2'd3;
`ifdef GRADIENT_THRESH_EN
    if (mag_w < thresh_q) begin
      mag_w = '0;
      ang_w = 2'd0;
    end
`endif
    wcol = idx - IW'(2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        sm_q[k] <= '0;
        df_q[k] <= '0;
      end
      gx_q <= '0; gy_q <= '0;
      grad_mag <= '0; grad_angle <= '0;
    end else if (state == RUN) begin
      if (idx < IW'(N)) begin
        for (int k = 0; k < 3; k++) begin
          sm_q[k] <= sm_n[k];
          df_q[k] <= df_n[k];
        end
      end
      if (idx >= IW'(1) && idx <= IW'(N)) begin
        gx_q <= sm_q[2] - sm_q[0];
        gy_q <= df_q[0] + df_q[1] + df_q[1] + df_q[2];
      end
      if (idx >= IW'(2)) begin
        grad_mag[wcol*MAG_BITS +: MAG_BITS] <= mag_w;
        grad_angle[wcol*2 +: 2]             <= ang_w;
      end
    end
  end
endmodule

// File: tb/tb_gradient_engine.sv
// Directed bench for gradient_engine: a window/Sobel model predicts every row
// result, plus hand-computed literals; a second instance runs with MAG_SHIFT=1.
module tb_gradient_engine;
  localparam int TILE_W = 16, PIX_BITS = 8, MAG_BITS = 8;
  localparam int N = TILE_W - 2, W = TILE_W * PIX_BITS;
  localparam int MW = N * MAG_BITS, AW2 = N * 2;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, row_first = 1'b0;
  logic [W-1:0] row_in = '0;
  logic [MW-1:0] grad_mag, grad_mag1;
  logic [AW2-1:0] grad_angle, grad_angle1;
  logic busy, done, overrun, busy1, done1, overrun1;
`ifdef GRADIENT_THRESH_EN
  logic [MAG_BITS-1:0] mag_thresh = '0;
`endif

  int tests = 0, fails = 0;
  int m0[TILE_W], m1[TILE_W], m2[TILE_W];
  logic [MW-1:0] exp_mag_q[$], exp_mag1_q[$];
  logic [AW2-1:0] exp_ang_q[$], exp_ang1_q[$];

  always #5 clk = ~clk;

  gradient_engine #(.TILE_W(TILE_W), .PIX_BITS(PIX_BITS), .MAG_BITS(MAG_BITS), .MAG_SHIFT(3)) u_dut (
    .clk(clk), .rst(rst), .start(start), .row_first(row_first), .row_in(row_in),
`ifdef GRADIENT_THRESH_EN
    .mag_thresh(mag_thresh),
`endif
    .grad_mag(grad_mag), .grad_angle(grad_angle), .busy(busy), .done(done), .overrun(overrun));

  gradient_engine #(.TILE_W(TILE_W), .PIX_BITS(PIX_BITS), .MAG_BITS(MAG_BITS), .MAG_SHIFT(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .start(start), .row_first(row_first), .row_in(row_in),
`ifdef GRADIENT_THRESH_EN
    .mag_thresh(mag_thresh),
`endif
    .grad_mag(grad_mag1), .grad_angle(grad_angle1), .busy(busy1), .done(done1), .overrun(overrun1));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: Sobel on the 3-row window, L1 magnitude, slope-binned angle.
  function automatic int sm(int c); return m2[c] + 2 * m1[c] + m0[c]; endfunction
  function automatic int df(int c); return m0[c] - m2[c]; endfunction

  function automatic logic [MW+AW2-1:0] model_out(int shift);
    logic [MW-1:0] mv;
    logic [AW2-1:0] av;
    int gx, gy, ax, ay, mag, ang;
    mv = '0; av = '0;
    for (int c = 0; c < N; c++) begin
      gx = sm(c + 2) - sm(c);
      gy = df(c) + 2 * df(c + 1) + df(c + 2);
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      mag = (ax + ay) >> shift;
      if (mag > 255) mag = 255;
      if (5 * ay <= 2 * ax)              ang = 0;
      else if (5 * ax <= 2 * ay)         ang = 2;
      else if ((gx < 0) == (gy < 0))     ang = 1;
      else                               ang = 3;
      mv[c*8 +: 8] = mag[7:0];
      av[c*2 +: 2] = ang[1:0];
    end
    return {mv, av};
  endfunction

  function automatic void model_load(input logic [W-1:0] row, input bit first);
    logic [MW+AW2-1:0] o;
    for (int c = 0; c < TILE_W; c++) begin
      if (first) begin
        m2[c] = int'(row[c*PIX_BITS +: PIX_BITS]);
        m1[c] = m2[c];
      end else begin
        m2[c] = m1[c];
        m1[c] = m0[c];
      end
      m0[c] = int'(row[c*PIX_BITS +: PIX_BITS]);
    end
    o = model_out(3);
    exp_mag_q.push_back(o[MW+AW2-1:AW2]);
    exp_ang_q.push_back(o[AW2-1:0]);
    o = model_out(1);
    exp_mag1_q.push_back(o[MW+AW2-1:AW2]);
    exp_ang1_q.push_back(o[AW2-1:0]);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < TILE_W; c++) begin
      m0[c] = 0; m1[c] = 0; m2[c] = 0;
    end
    exp_mag_q.delete(); exp_ang_q.delete();
    exp_mag1_q.delete(); exp_ang1_q.delete();
  endfunction

  function automatic logic [W-1:0] mk_step(int lo, int hi);
    logic [W-1:0] r;
    for (int c = 0; c < TILE_W; c++)
      r[c*PIX_BITS +: PIX_BITS] = PIX_BITS'((c < TILE_W / 2) ? lo : hi);
    return r;
  endfunction

  // Scoreboard: every done pulse must deliver the model's next row result.
  always @(negedge clk) begin
    if (!rst && (done || done1)) begin
      if (exp_mag_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got done=%0b/%0b expected no pending row", done, done1);
      end else begin
        check("done_s3", done, 1);
        check("done_s1", done1, 1);
        check("mag_s3", grad_mag, exp_mag_q.pop_front());
        check("ang_s3", grad_angle, exp_ang_q.pop_front());
        check("mag_s1", grad_mag1, exp_mag1_q.pop_front());
        check("ang_s1", grad_angle1, exp_ang1_q.pop_front());
      end
    end
  end

  task automatic start_op(input logic [W-1:0] row, input bit first);
    @(negedge clk);
    start = 1'b1; row_first = first; row_in = row;
    model_load(row, first);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // ovr_at / rst_at: idx value at which to inject a busy start or a reset (-1 = none).
  task automatic run_row(input logic [W-1:0] row, input bit first, input int ovr_at, input int rst_at);
    int cnt;
    bit got;
    cnt = 0; got = 1'b0;
    start_op(row, first);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) cnt++;
      if (rst_at >= 0 && cnt == rst_at + 1) begin
        rst = 1'b1;
        #1;
        check("rst_mag", grad_mag, 0);
        check("rst_ang", grad_angle, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovr", overrun, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (ovr_at >= 0 && cnt == ovr_at + 1) begin
        start = 1'b1; row_first = 1'b1; row_in = ~row;
      end
      if (ovr_at >= 0 && cnt == ovr_at + 2) begin
        start = 1'b0;
        check("overrun_pulse", overrun, 1);
      end
      if (ovr_at >= 0 && cnt == ovr_at + 3) check("overrun_clear", overrun, 0);
    end
    check("done_seen", got, 1);
    check("busy_cycles", cnt, N + 2);
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  task automatic b2b(input logic [W-1:0] row_a, input logic [W-1:0] row_b);
    int gap;
    bit got;
    got = 1'b0;
    start_op(row_a, 1'b1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("b2b_first_done", got, 1);
    start = 1'b1; row_first = 1'b0; row_in = row_b;
    model_load(row_b, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    gap = 0; got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      gap++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("b2b_second_done", got, 1);
    check("b2b_gap", gap, 17);
  endtask

  logic [MW-1:0] lit_mag;
  logic [W-1:0] rnd;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_mag", grad_mag, 0);
    check("reset_ang", grad_angle, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ovr", overrun, 0);
    rst = 1'b0;

    // Flat field: no gradient anywhere.
    run_row(mk_step(100, 100), 1'b1, -1, -1);
    check("flat_mag", grad_mag, 0);
    check("flat_ang", grad_angle, 0);

    // Vertical edge 0/200 between pixels 7 and 8.
    run_row(mk_step(0, 200), 1'b1, -1, -1);
    lit_mag = '0; lit_mag[6*8 +: 8] = 8'd100; lit_mag[7*8 +: 8] = 8'd100;
    check("vstep_mag", grad_mag, lit_mag);
    check("vstep_ang", grad_angle, 0);
    lit_mag = '0; lit_mag[6*8 +: 8] = 8'd255; lit_mag[7*8 +: 8] = 8'd255;
    check("vstep_mag_sat", grad_mag1, lit_mag);

    // Reset at idx=5, then a normal operation on the cleared window.
    run_row(mk_step(30, 90), 1'b1, -1, 5);
    run_row(mk_step(0, 200), 1'b0, -1, -1);

    // Horizontal edge: row of 0 then row of 200.
    run_row(mk_step(0, 0), 1'b1, -1, -1);
    run_row(mk_step(200, 200), 1'b0, -1, -1);
    check("hstep_mag", grad_mag, {N{8'd100}});
    check("hstep_ang", grad_angle, {N{2'd2}});

    // Full-range edge saturates the MAG_SHIFT=1 instance.
    run_row(mk_step(0, 255), 1'b1, -1, -1);
    lit_mag = '0; lit_mag[6*8 +: 8] = 8'd127; lit_mag[7*8 +: 8] = 8'd127;
    check("fstep_mag", grad_mag, lit_mag);
    lit_mag = '0; lit_mag[6*8 +: 8] = 8'd255; lit_mag[7*8 +: 8] = 8'd255;
    check("fstep_mag_sat", grad_mag1, lit_mag);
    check("fstep_ang_sat", grad_angle1, 0);

    // Start while busy is ignored and flagged.
    rnd = {$urandom, $urandom, $urandom, $urandom};
    run_row(rnd, 1'b0, 3, -1);

    // Start on the done cycle is accepted.
    b2b({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    @(negedge clk);

    // Arbitrary textures to reach the diagonal angle bins.
    for (int i = 0; i < 4; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      run_row(rnd, 1'b0, -1, -1);
    end

    check("exp_q_drained", exp_mag_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
